lut_access_arbiter: RTL



---
 rtl/lut_access_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lut_access_arbiter.sv
// lut_access_arbiter
//   Round-robin arbiter and sequencer that shares one 16x4 lookupTable between
//   two requesters. One transaction is in flight at a time; reads wait out the
//   table latency (READ_LAT) and return data to the requester that issued them.
//   Every output is registered.
//   Optional build macro: LUT_ARB_STATS_EN adds saturating grant/busy counters.
module lut_access_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int READ_LAT = 1      // legal range 1..7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          wr,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   tblAddrW,
    output logic [ADDR_W-1:0]   tblAddrR,
    output logic                tblWE,
    output logic                tblRE,
    output logic [DATA_W-1:0]   tblDataIn,
    input  logic [DATA_W-1:0]   tblDataOut
`ifdef LUT_ARB_STATS_EN
    ,
    output logic [7:0]          grantCnt0,
    output logic [7:0]          grantCnt1,
    output logic [7:0]          busyCnt
`endif
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;       // requester that wins the next tie
    logic               win_q, win_d;       // requester owning the current op
    logic               op_wr_q, op_wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  addr_w_q, addr_w_d;
    logic [ADDR_W-1:0]  addr_r_q, addr_r_d;
    logic               we_q, we_d;
    logic               re_q, re_d;
    logic [DATA_W-1:0]  data_in_q, data_in_d;

    // Winner selection: a lone requester wins outright, a tie goes to ptr_q.
    logic               win_sel;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    assign win_sel   = (req == 2'b11) ? ptr_q : req[1];
    assign sel_addr  = win_sel ? addr[ADDR_W +: ADDR_W]  : addr[0 +: ADDR_W];
    assign sel_wdata = win_sel ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        gnt_d     = 2'b00;
        rvalid_d  = 2'b00;
        rdata_d   = rdata_q;
        addr_w_d  = addr_w_q;
        addr_r_d  = addr_r_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        data_in_d = data_in_q;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    win_d          = win_sel;
                    ptr_d          = ~win_sel;
                    op_wr_d        = wr[win_sel];
                    gnt_d[win_sel] = 1'b1;
                    state_d        = ISSUE;
                    if (wr[win_sel]) begin
                        we_d      = 1'b1;
                        addr_w_d  = sel_addr;
                        data_in_d = sel_wdata;
                    end else begin
                        re_d     = 1'b1;
                        addr_r_d = sel_addr;
                    end
                end
            end
            ISSUE: begin
                if (op_wr_q) begin
                    state_d = IDLE;
                end else begin
                    re_d    = 1'b1;
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d         = tblDataOut;
                    rvalid_d[win_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    re_d  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchronous reset aborts any in-flight op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            op_wr_q   <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            rvalid_q  <= 2'b00;
            rdata_q   <= '0;
            addr_w_q  <= '0;
            addr_r_q  <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            op_wr_q   <= op_wr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            addr_w_q  <= addr_w_d;
            addr_r_q  <= addr_r_d;
            we_q      <= we_d;
            re_q      <= re_d;
            data_in_q <= data_in_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign tblAddrW  = addr_w_q;
    assign tblAddrR  = addr_r_q;
    assign tblWE     = we_q;
    assign tblRE     = re_q;
    assign tblDataIn = data_in_q;

`ifdef LUT_ARB_STATS_EN
    logic [7:0] grant_cnt0_q, grant_cnt1_q, busy_cnt_q;

    // Saturating grant and busy-cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            busy_cnt_q   <= '0;
        end else begin
            if (gnt_q[0] && (grant_cnt0_q != 8'hFF)) grant_cnt0_q <= grant_cnt0_q + 8'd1;
            if (gnt_q[1] && (grant_cnt1_q != 8'hFF)) grant_cnt1_q <= grant_cnt1_q + 8'd1;
            if ((state_q != IDLE) && (busy_cnt_q != 8'hFF)) busy_cnt_q <= busy_cnt_q + 8'd1;
        end
    end

    assign grantCnt0 = grant_cnt0_q;
    assign grantCnt1 = grant_cnt1_q;
    assign busyCnt   = busy_cnt_q;
`endif

endmodule
